// File: rtl/dev_timer_pkg.sv
// Shared definitions for the dev_timer block: register map, CTRL fields,
// MODE codes, FSM encoding and the byte-lane write merge.
package dev_timer_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'b00;
    localparam logic [1:0] ADDR_PRESET = 2'b01;
    localparam logic [1:0] ADDR_COUNT  = 2'b10;
    localparam logic [1:0] ADDR_RSVD   = 2'b11;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;
    localparam int CTRL_W       = 4;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_CNT  = 2'b10,
        ST_INT  = 2'b11
    } state_t;

    // Lane i of the result comes from new_val when be[i] is set, else old_val.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dev_timer.sv
// Memory-mapped down-counting timer with one-shot / auto-reload modes and a
// maskable interrupt flag.
module dev_timer
    import dev_timer_pkg::*;
#(
    parameter logic [31:0] PRESET_RST = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [3:0]  BE,
    input  logic [31:0] DIN,
    output logic [31:0] DOUT,
    output logic        IRQ
);

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [31:0]       preset_q, preset_d;
    logic [31:0]       count_q, count_d;
    state_t            state_q, state_d;
    logic              irq_flag_q, irq_flag_d;

    logic       en;
    logic       im;
    logic [1:0] mode;
    logic       wr_ctrl, wr_preset;
    logic       im_toggle;
    logic       irq_set, irq_hw_clr, hw_en_clr;

    assign en   = ctrl_q[CTRL_EN];
    assign im   = ctrl_q[CTRL_IM];
    assign mode = ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO];

    assign wr_ctrl   = WE && (Addr == ADDR_CTRL);
    assign wr_preset = WE && (Addr == ADDR_PRESET);
    assign im_toggle = wr_ctrl && BE[0] && (DIN[CTRL_IM] != im);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        irq_set    = 1'b0;
        irq_hw_clr = 1'b0;
        hw_en_clr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d = 32'd0;
                    state_d = ST_INT;
                    irq_set = 1'b1;
                end
            end
            ST_INT: begin
                if (mode == MODE_RELOAD) begin
                    state_d    = ST_LOAD;
                    irq_hw_clr = 1'b1;
                end else begin
                    state_d   = ST_IDLE;
                    hw_en_clr = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A CPU write to CTRL lands after the hardware EN clear, so it wins.
    always_comb begin
        ctrl_d = ctrl_q;
        if (hw_en_clr) ctrl_d[CTRL_EN] = 1'b0;
        if (wr_ctrl && BE[0]) ctrl_d = DIN[CTRL_W-1:0];
    end

    assign preset_d = wr_preset ? merge_bytes(preset_q, DIN, BE) : preset_q;

    // CTRL writes that flip IM are pure mask operations and keep the pending
    // flag; any other CTRL or PRESET write acknowledges it.
    always_comb begin
        irq_flag_d = irq_flag_q;
        if (irq_hw_clr || wr_preset || (wr_ctrl && !im_toggle)) irq_flag_d = 1'b0;
        if (irq_set) irq_flag_d = 1'b1;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ctrl_q     <= '0;
            preset_q   <= PRESET_RST;
            count_q    <= '0;
            state_q    <= ST_IDLE;
            irq_flag_q <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            state_q    <= state_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    always_comb begin
        DOUT = '0;
        case (Addr)
            ADDR_CTRL:   DOUT = {{(32-CTRL_W){1'b0}}, ctrl_q};
            ADDR_PRESET: DOUT = preset_q;
            ADDR_COUNT:  DOUT = count_q;
            ADDR_RSVD:   DOUT = '0;
            default:     DOUT = '0;
        endcase
    end

    assign IRQ = irq_flag_q & im;

endmodule
